rf_wr_ctrl: RTL

RF_WR_CTRL -- requirements
Module: rf_wr_ctrl

---
 rtl/rf_wr_ctrl.sv | 110 +++++++++++
 1 files changed

// File: rtl/rf_wr_ctrl.sv
// Write-port controller for a register file: round-robin arbitration between two
// requesters plus a clear sequence that writes CLR_VALUE to every register.
module rf_wr_ctrl #(
   parameter int                 ADR_WL    = 4,
   parameter int                 DATA_WL   = 16,
   parameter int                 REG_CNT   = 16,
   parameter logic [DATA_WL-1:0] CLR_VALUE = '0
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               req0,
   input  logic               req1,
   input  logic [ADR_WL-1:0]  adr0,
   input  logic [ADR_WL-1:0]  adr1,
   input  logic [DATA_WL-1:0] data0,
   input  logic [DATA_WL-1:0] data1,
   input  logic               clr_req,
   output logic               gnt0,
   output logic               gnt1,
   output logic               rf_we,
   output logic [ADR_WL-1:0]  rf_adr,
   output logic [DATA_WL-1:0] rf_data,
   output logic               busy,
   output logic               clr_done
);

   typedef enum logic {IDLE, CLEAR} state_t;

   localparam logic [ADR_WL-1:0] LAST_ADR = ADR_WL'(REG_CNT - 1);

   state_t             state;
   state_t             state_next;
   logic [ADR_WL-1:0]  cnt;
   logic               ptr;
   logic               last_clr;
   logic               we_next;
   logic [ADR_WL-1:0]  adr_next;
   logic [DATA_WL-1:0] data_next;
   logic               busy_next;
   logic               done_next;

   assign last_clr = (state == CLEAR) && (cnt == LAST_ADR);

   // cnt sits at 0 throughout IDLE, so every clear starts at address 0.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         cnt   <= '0;
         ptr   <= 1'b0;
      end else begin
         state <= state_next;
         cnt   <= (state == CLEAR) ? cnt + 1'b1 : '0;
         if (gnt0 || gnt1) ptr <= gnt0;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (clr_req)  state_next = CLEAR;
         CLEAR:   if (last_clr) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      gnt0      = 1'b0;
      gnt1      = 1'b0;
      we_next   = 1'b0;
      adr_next  = rf_adr;
      data_next = rf_data;
      // A clear request outranks both writers in the cycle it arrives.
      if (!reset && state == IDLE && !clr_req) begin
         if (req0 && (!req1 || !ptr)) gnt0 = 1'b1;
         else if (req1)               gnt1 = 1'b1;
      end
      if (gnt0) begin
         we_next   = 1'b1;
         adr_next  = adr0;
         data_next = data0;
      end else if (gnt1) begin
         we_next   = 1'b1;
         adr_next  = adr1;
         data_next = data1;
      end else if (state == CLEAR) begin
         we_next   = 1'b1;
         adr_next  = cnt;
         data_next = CLR_VALUE;
      end
      busy_next = (state_next == CLEAR);
      done_next = last_clr;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rf_we    <= 1'b0;
         rf_adr   <= '0;
         rf_data  <= '0;
         busy     <= 1'b0;
         clr_done <= 1'b0;
      end else begin
         rf_we    <= we_next;
         rf_adr   <= adr_next;
         rf_data  <= data_next;
         busy     <= busy_next;
         clr_done <= done_next;
      end
   end

endmodule
